// File: rtl/axi4lite_slave_ctrl.sv
// AXI4-Lite slave controller: arbitrates write (AW+W) and read (AR) requests
// round-robin and sequences one access at a time to a word-addressed memory.
`timescale 1ns/1ps
module axi4lite_slave_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [IDX_W-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ACCESS, S_WR_RESP, S_RD_ACCESS, S_RD_WAIT, S_RD_RESP
  } state_t;

  typedef enum logic {G_WRITE, G_READ} grant_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t state;
  grant_t last_grant;
  logic   err;
  logic   wr_req, rd_req, wr_grant, rd_grant;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> 2) < ADDR_WIDTH'(MEM_DEPTH);
  endfunction

  // Handshake: a channel transfers on the rising edge where VALID && READY.
  // READY is only offered in IDLE to the granted request, so AW and W are
  // always taken together in that same cycle; B/R VALID hold until READY.
  always_comb begin
    wr_req   = AWVALID && WVALID;
    rd_req   = ARVALID;
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    if (state == S_IDLE) begin
      if (wr_req && rd_req) begin
        wr_grant = (last_grant == G_READ);
        rd_grant = (last_grant == G_WRITE);
      end else begin
        wr_grant = wr_req;
        rd_grant = rd_req;
      end
    end
  end

  assign AWREADY   = wr_grant;
  assign WREADY    = wr_grant;
  assign ARREADY   = rd_grant;
  assign dbg_state = state;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= S_IDLE;
      last_grant <= G_WRITE;
      err        <= 1'b0;
      BRESP      <= '0;
      BVALID     <= 1'b0;
      RDATA      <= '0;
      RRESP      <= '0;
      RVALID     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (wr_grant) begin
            state     <= S_WR_ACCESS;
            err       <= !in_range(AWADDR);
            mem_en    <= in_range(AWADDR);
            mem_we    <= 1'b1;
            mem_addr  <= AWADDR[IDX_W+1:2];
            mem_wdata <= WDATA;
            mem_wstrb <= WSTRB;
            if (rd_req) last_grant <= G_WRITE;
          end else if (rd_grant) begin
            state    <= S_RD_ACCESS;
            err      <= !in_range(ARADDR);
            mem_en   <= in_range(ARADDR);
            mem_we   <= 1'b0;
            mem_addr <= ARADDR[IDX_W+1:2];
            if (wr_req) last_grant <= G_READ;
          end
        end
        S_WR_ACCESS: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_wstrb <= '0;
          BVALID    <= 1'b1;
          BRESP     <= err ? RESP_SLVERR : RESP_OKAY;
          state     <= S_WR_RESP;
        end
        S_WR_RESP: begin
          if (BREADY) begin
            BVALID <= 1'b0;
            state  <= S_IDLE;
          end
        end
        S_RD_ACCESS: begin
          mem_en   <= 1'b0;
          mem_addr <= '0;
          state    <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          // mem_rdata is valid this cycle, one cycle after the strobe.
          RDATA  <= err ? '0 : mem_rdata;
          RRESP  <= err ? RESP_SLVERR : RESP_OKAY;
          RVALID <= 1'b1;
          state  <= S_RD_RESP;
        end
        S_RD_RESP: begin
          if (RREADY) begin
            RVALID <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_slave_ctrl.sv
// Bench for axi4lite_slave_ctrl: directed scenarios plus random traffic,
// checked by a scoreboard against a word-array reference model.
`timescale 1ns/1ps
module tb_axi4lite_slave_ctrl;

  localparam int MEM_DEPTH = 256;

  logic        clk = 1'b0;
  logic        ARESETn = 1'b0;
  logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
  logic [3:0]  WSTRB = '0;
  logic        AWVALID = 1'b0, WVALID = 1'b0, ARVALID = 1'b0;
  logic        BREADY = 1'b0, RREADY = 1'b0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic [2:0]  dbg_state;

  axi4lite_slave_ctrl dut (
    .ACLK(clk), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- attached memory ----------------
  logic [31:0] tb_mem  [MEM_DEPTH];
  logic [31:0] ref_mem [MEM_DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) tb_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= tb_mem[mem_addr];
      end
    end
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0, n_fail = 0;
  logic [76:0] exp_mem_q[$];   // {cycle, we, idx, wdata, wstrb}
  logic [33:0] exp_b_q[$];     // {cycle, bresp}
  logic [65:0] exp_r_q[$];     // {cycle, rresp, rdata}
  bit   model_last = 1'b0;     // 0: WRITE granted last, 1: READ
  bit   rdy_mode = 1'b1;       // 1: BREADY/RREADY high, 0: random
  bit   b_hold = 1'b0;
  int   b_hs_cyc = -1;
  int   last_w_t = 0, last_r_t = 0;
  bit   tie_seen = 1'b0, tie_winner = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic accept_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a >> 2);
    bit oor = (idx >= MEM_DEPTH);
    last_w_t = cyc;
    if (!oor) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      exp_mem_q.push_back({32'(cyc + 1), 1'b1, 8'(idx), d, s});
    end
    exp_b_q.push_back({32'(cyc + 2), oor ? 2'b10 : 2'b00});
  endtask

  task automatic accept_read(input logic [31:0] a);
    int idx = int'(a >> 2);
    bit oor = (idx >= MEM_DEPTH);
    last_r_t = cyc;
    if (!oor) exp_mem_q.push_back({32'(cyc + 1), 1'b0, 8'(idx), 32'h0, 4'h0});
    exp_r_q.push_back({32'(cyc + 3), oor ? 2'b10 : 2'b00, oor ? 32'h0 : ref_mem[idx]});
  endtask

  // ---------------- driver ----------------
  task automatic issue(input bit do_w, input bit do_r, input logic [31:0] wa,
                       input logic [31:0] wd, input logic [3:0] ws,
                       input logic [31:0] ra, input int w_lag);
    bit wp = do_w, rp = do_r, win;
    int it = 0;
    tie_seen = 1'b0;
    while ((wp || rp) && it < 60) begin
      @(negedge clk);
      AWADDR = wa; WDATA = wd; WSTRB = ws; ARADDR = ra;
      AWVALID = wp; WVALID = wp && (it >= w_lag); ARVALID = rp;
      #1;
      if (!(AWVALID && WVALID)) chk("awready_without_req", {AWREADY, WREADY}, 2'b00);
      if (!ARVALID) chk("arready_without_req", ARREADY, 1'b0);
      chk("ready_exclusive", AWREADY && ARREADY, 1'b0);
      if (AWREADY) chk("wready_with_awready", WREADY, 1'b1);
      if (w_lag > 0 && it == w_lag) chk("aw_w_same_cycle", {AWREADY, WREADY}, 2'b11);
      if (AWVALID && WVALID && ARVALID && (AWREADY || ARREADY)) begin
        win = ARREADY;
        chk("rr_winner", win, !model_last);
        if (!tie_seen) begin tie_seen = 1'b1; tie_winner = win; end
        model_last = !model_last;
      end
      if (AWREADY && wp) begin accept_write(wa, wd, ws); wp = 1'b0; end
      else if (ARREADY && rp) begin accept_read(ra); rp = 1'b0; end
      it++;
    end
    if (wp || rp) chk("issue_timeout", {wp, rp}, 2'b00);
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_b_q.size() != 0 || exp_r_q.size() != 0 || exp_mem_q.size() != 0 ||
            BVALID || RVALID) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'(exp_b_q.size() + exp_r_q.size()), 32'h0);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 32'h400 + 32'($urandom_range(0, 65535));
    return 32'($urandom_range(0, 1023));
  endfunction

  // ---------------- response-side ready driver ----------------
  initial begin : responder
    forever begin
      @(posedge clk); #1;
      BREADY = b_hold ? 1'b0 : (rdy_mode ? 1'b1 : ($urandom_range(0, 3) != 0));
      RREADY = rdy_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [76:0] em;
    logic [33:0] eb;
    logic [65:0] er;
    bit          b_open = 1'b0, r_open = 1'b0;
    logic [1:0]  b_exp = '0;
    logic [33:0] r_exp = '0;
    forever begin
      @(negedge clk); #2;
      if (!ARESETn) begin
        b_open = 1'b0; r_open = 1'b0;
      end else begin
        if (mem_en) begin
          if (exp_mem_q.size() == 0) chk("mem_unexpected_access", mem_en, 1'b0);
          else begin
            em = exp_mem_q.pop_front();
            chk("mem_port", {32'(cyc), mem_we, mem_addr, mem_we ? mem_wdata : 32'h0,
                             mem_we ? mem_wstrb : 4'h0}, em);
          end
        end
        if (BVALID) begin
          if (!b_open) begin
            if (exp_b_q.size() == 0) begin chk("b_unexpected", BVALID, 1'b0); b_exp = BRESP; end
            else begin
              eb = exp_b_q.pop_front();
              chk("b_resp_timing", {32'(cyc), BRESP}, eb);
              b_exp = eb[1:0];
            end
            b_open = 1'b1;
          end else chk("b_stable", BRESP, b_exp);
          if (BREADY) begin b_open = 1'b0; b_hs_cyc = cyc; end
        end else if (b_open) begin
          chk("b_dropped", BVALID, 1'b1); b_open = 1'b0;
        end
        if (RVALID) begin
          if (!r_open) begin
            if (exp_r_q.size() == 0) begin chk("r_unexpected", RVALID, 1'b0); r_exp = {RRESP, RDATA}; end
            else begin
              er = exp_r_q.pop_front();
              chk("r_resp_timing", {32'(cyc), RRESP, RDATA}, er);
              r_exp = er[33:0];
            end
            r_open = 1'b1;
          end else chk("r_stable", {RRESP, RDATA}, r_exp);
          if (RREADY) r_open = 1'b0;
        end else if (r_open) begin
          chk("r_dropped", RVALID, 1'b1); r_open = 1'b0;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    bit [2:0] ties;
    int t_w, t_r;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
                          mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb}, 87'h0);
    chk("reset_state", dbg_state, 3'd0);
    @(negedge clk);
    ARESETn = 1'b1;

    // basic write then read-back
    issue(1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    issue(0, 1, 32'h0, 32'h0, 4'h0, 32'h10, 0);
    drain();

    // three simultaneous AW+W / AR requests
    for (int k = 0; k < 3; k++) begin
      issue(1, 1, 32'h20 + 32'(4 * k), $urandom, 4'hF, 32'h20 + 32'(4 * k), 0);
      ties[k] = tie_winner;
      drain();
    end
    chk("tie_sequence", ties, 3'b101);

    // out-of-range write and read
    issue(1, 0, 32'h400, 32'h12345678, 4'hF, 32'h0, 0);
    issue(0, 1, 32'h0, 32'h0, 4'h0, 32'h400, 0);
    drain();

    // AWVALID alone for 5 cycles, then WVALID joins
    issue(1, 0, 32'h44, 32'hA5A5_0F0F, 4'h5, 32'h0, 5);
    issue(1, 0, 32'h48, 32'hFFFF_FFFF, 4'h0, 32'h0, 0);
    issue(0, 1, 32'h0, 32'h0, 4'h0, 32'h44, 0);
    drain();

    // BREADY withheld 4 cycles while a read waits
    b_hold = 1'b1;
    repeat (2) @(negedge clk);
    issue(1, 0, 32'h50, 32'h0BAD_F00D, 4'hF, 32'h0, 0);
    t_w = last_w_t;
    fork
      issue(0, 1, 32'h0, 32'h0, 4'h0, 32'h50, 0);
      begin
        while (cyc < t_w + 5) @(negedge clk);
        b_hold = 1'b0;
      end
    join
    chk("b_handshake_cycle", 32'(b_hs_cyc), 32'(t_w + 6));
    chk("ar_after_b_handshake", 32'(last_r_t), 32'(t_w + 7));
    drain();

    // reset during RD_WAIT
    issue(0, 1, 32'h0, 32'h0, 4'h0, 32'h10, 0);
    t_r = last_r_t;
    while (cyc < t_r + 2) @(negedge clk);
    ARESETn = 1'b0;
    #1;
    chk("midreset_rvalid", RVALID, 1'b0);
    chk("midreset_mem_en", mem_en, 1'b0);
    chk("midreset_outputs", {AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
                             mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb}, 87'h0);
    chk("midreset_state", dbg_state, 3'd0);
    exp_r_q.delete(); exp_b_q.delete(); exp_mem_q.delete();
    model_last = 1'b0;
    repeat (2) @(negedge clk);
    ARESETn = 1'b1;
    issue(0, 1, 32'h0, 32'h0, 4'h0, 32'h10, 0);
    drain();

    // random mixed traffic
    for (int i = 0; i < 150; i++) begin
      int kind;
      logic [31:0] wa, ra, wd;
      logic [3:0] ws;
      if (i % 25 == 0) rdy_mode = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 2);
      wa = rand_addr(); ra = rand_addr(); wd = $urandom; ws = 4'($urandom_range(0, 15));
      issue(kind != 1, kind != 0, wa, wd, ws, ra, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rdy_mode = 1'b1;
    drain();
    chk("queues_empty", 32'(exp_b_q.size() + exp_r_q.size() + exp_mem_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4lite_slave_ctrl.md
Name: axi4lite_slave_ctrl

Overview:
- AXI4-Lite slave-side controller that sequences all accesses to a single-port, word-addressed register memory.
- Accepts write (AW+W) and read (AR) requests and arbitrates when both arrive together, using round-robin between the WRITE and READ operations.
- Drives one memory access at a time and returns the B or R response.
- Sits between the bus interface and the register array; it is the DUT the agent's READ/WRITE/BOTH traffic exercises.

Parameters:
ADDR_WIDTH, 32, byte-address width of AWADDR/ARADDR
DATA_WIDTH, 32, data width (must be 32 or 64)
MEM_DEPTH, 256, number of words in attached memory
IDX_W, $clog2(MEM_DEPTH), memory index width (derived)

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESETn  in  1  reset, asynchronous assert, active-low
AWADDR  in  ADDR_WIDTH  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte strobes
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_WIDTH  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response
RVALID  out  1  read response valid
RREADY  in  1  read response ready
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  IDX_W  word index
mem_wdata  out  DATA_WIDTH  write data to memory
mem_wstrb  out  DATA_WIDTH/8  byte enables to memory
mem_rdata  in  DATA_WIDTH  read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset (ARESETn low, asynchronous):
  - state=IDLE; last_grant=WRITE, so the first tie goes to READ.
  - Every output is 0, including BRESP, RRESP and RDATA.
  - Any in-flight transaction is dropped with no response.
- States: IDLE, WR_ACCESS, WR_RESP, RD_ACCESS, RD_WAIT, RD_RESP.
- Write request: wr_req = AWVALID && WVALID. AW and W are never accepted separately.
- Read request: rd_req = ARVALID.
- IDLE grant (combinational):
  - Only one request present: it wins.
  - Both present: the operation other than last_grant wins, and last_grant updates to the winner.
- Ready signals:
  - AWREADY = WREADY = (IDLE && wr_grant).
  - ARREADY = (IDLE && rd_grant).
  - All are 0 in every other state, so the handshake completes in the grant cycle T.
- On accept: address, WDATA and WSTRB are latched.
  - Word index = ADDR[IDX_W+1:2]; ADDR[1:0] is ignored.
  - Address is out of range when (ADDR>>2) >= MEM_DEPTH.
- Write path:
  - T+1 WR_ACCESS: mem_en=1, mem_we=1, mem_addr/mem_wdata/mem_wstrb driven for exactly one cycle. If out of range, mem_en=0.
  - T+2 WR_RESP: BVALID=1; BRESP=2'b00 (OKAY) or 2'b10 (SLVERR) if out of range. Held stable until BREADY.
  - Return to IDLE the cycle after the BVALID&&BREADY handshake.
  - WSTRB=0 still performs the access and returns OKAY.
- Read path:
  - T+1 RD_ACCESS: mem_en=1, mem_we=0. If out of range, mem_en=0.
  - T+2 RD_WAIT: RDATA latched from mem_rdata; RDATA=0 if out of range.
  - T+3 RD_RESP: RVALID=1; RRESP OKAY/SLVERR. RDATA/RRESP held until RREADY.
  - Then IDLE.
- mem_en/mem_we are 0 outside the access states.
- Back-to-back: a new grant is possible in the first IDLE cycle after a response handshake.
- Minimum period per transaction: 3 cycles write, 4 cycles read, with BREADY/RREADY held high.
- Requests held during a busy period are not acknowledged. They are arbitrated on return to IDLE, with the round-robin state preserved.
- BREADY/RREADY asserted before BVALID/RVALID has no effect.
- VALID deasserted before its READY arrives (protocol violation): request simply not taken; no state change.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x10 with WSTRB=4'hF, then read 0x10 → mem write of index 4 at T+1, BRESP=0 at T+2; RDATA=0xDEADBEEF, RRESP=0 at T+3.
- AW+W and AR raised the same cycle, three times in a row → grants READ, WRITE, READ; ARREADY and AWREADY never high together.
- Out-of-range address 0x400 (MEM_DEPTH=256) read and written → mem_en stays 0; BRESP=2'b10; RRESP=2'b10, RDATA=0.
- Only AWVALID high, WVALID low for 5 cycles → AWREADY stays 0; WVALID rises → AWREADY=WREADY=1 that same cycle.
- BREADY held low for 4 cycles → BVALID/BRESP stable; pending ARVALID not accepted until the cycle after the B handshake.
- ARESETn pulled low during RD_WAIT → RVALID, mem_en and all other outputs 0 immediately; after release a new read completes normally.
